// File: rtl/scale_ctrl.sv
// rtl/scale_ctrl.sv - image scaling sequencer: ROM fetch, downscale/upscale handshakes, timeout
module scale_ctrl #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int ROM_LAT    = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic                  stall_i,
    output logic                  rom_en_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  rd_data_valid_o,
    input  logic                  ds_done_i,
    output logic                  us_run_o,
    input  logic                  us_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
    localparam logic [ROM_LAT-1:0] OUT_STAGE = ROM_LAT'(1) << (ROM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, FLUSH, WAIT_DS, RUN_US, WAIT_US, DONE
    } state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ROM_LAT-1:0]      vsr;
    logic [TW-1:0]           tcnt;
    logic                    mode_q, ds_seen, us_seen, err_q;
    logic                    accept, last_read, flush_done, tmo, set_err;

    assign accept    = (state == IDLE) && start_i;
    assign rom_en_o  = (state == FETCH) && !stall_i;
    assign last_read = rom_en_o && (addr == LAST_ADDR);
    assign tmo       = (tcnt == TLIM);
    // No reads are issued in FLUSH, so only the output stage left set means
    // the register drains to zero at this edge.
    assign flush_done = (vsr & ~OUT_STAGE) == '0;

    assign rom_addr_o      = addr;
    assign rd_data_valid_o = vsr[ROM_LAT-1];
    assign us_run_o        = (state == RUN_US);
    assign done_o          = (state == DONE);
    assign busy_o          = (state != IDLE);
    assign err_o           = err_q;

    always_comb begin
        state_nx = state;
        set_err  = 1'b0;
        case (state)
            IDLE:    if (start_i) state_nx = FETCH;
            FETCH:   if (last_read) state_nx = FLUSH;
            FLUSH:   if (flush_done) state_nx = WAIT_DS;
            WAIT_DS: begin
                if (ds_seen || ds_done_i) begin
                    state_nx = mode_q ? RUN_US : DONE;
                end else if (tmo) begin
                    state_nx = IDLE;
                    set_err  = 1'b1;
                end
            end
            RUN_US:  state_nx = WAIT_US;
            WAIT_US: begin
                if (us_seen || us_done_i) begin
                    state_nx = DONE;
                end else if (tmo) begin
                    state_nx = IDLE;
                    set_err  = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            vsr     <= '0;
            tcnt    <= '0;
            mode_q  <= 1'b0;
            ds_seen <= 1'b0;
            us_seen <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            vsr[0] <= rom_en_o;
            for (int i = 1; i < ROM_LAT; i++) begin
                vsr[i] <= vsr[i-1];
            end
            if (accept) begin
                mode_q  <= mode_i;
                addr    <= '0;
                err_q   <= 1'b0;
                ds_seen <= 1'b0;
                us_seen <= 1'b0;
            end else begin
                if (rom_en_o) begin
                    addr <= last_read ? '0 : addr + 1'b1;
                end
                // Early done pulses are remembered so they survive until the wait state.
                if (ds_done_i && (state == FETCH || state == FLUSH || state == WAIT_DS)) begin
                    ds_seen <= 1'b1;
                end
                if (us_done_i && (state == RUN_US || state == WAIT_US)) begin
                    us_seen <= 1'b1;
                end
                if (set_err) begin
                    err_q <= 1'b1;
                end
            end
            if ((state == WAIT_DS || state == WAIT_US) && state_nx == state) begin
                tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_scale_ctrl.sv
// tb/tb_scale_ctrl.sv - scoreboard bench for scale_ctrl with an event-timing reference model
module tb_scale_ctrl;
    localparam int W = 4, H = 4, AW = 4, LAT = 1, TMO = 8;
    localparam int NPIX = W * H;
    localparam int MAXR = 256;
    localparam int E_EN = 0, E_VAL = 1, E_RUN = 2, E_DONE = 3, E_BR = 4, E_BF = 5, E_ER = 6, E_EF = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_i = 1'b0, mode_i = 1'b0, stall_i = 1'b0, ds_done_i = 1'b0, us_done_i = 1'b0;
    logic rom_en_o, rd_data_valid_o, us_run_o, busy_o, done_o, err_o;
    logic [AW-1:0] rom_addr_o;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int eq[8][$];
    int q_addr[$];
    bit err_exp = 1'b0;
    logic busy_p = 1'b0, err_p = 1'b0;

    scale_ctrl #(
        .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW), .ROM_LAT(LAT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .stall_i(stall_i),
        .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rd_data_valid_o(rd_data_valid_o),
        .ds_done_i(ds_done_i), .us_run_o(us_run_o), .us_done_i(us_done_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic evt(input int k, input string name);
        tests++;
        if (eq[k].size() == 0) begin
            fails++;
            $display("FAIL %s: event at cycle %0d, none expected", name, cyc);
        end else begin
            int e;
            e = eq[k].pop_front();
            if (e != cyc) begin
                fails++;
                $display("FAIL %s: event at cycle %0d, expected at cycle %0d", name, cyc, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rom_en_o) begin
            evt(E_EN, "rom_en");
            if (q_addr.size() > 0) check("rom_addr", int'(rom_addr_o), q_addr.pop_front());
        end
        if (rd_data_valid_o) evt(E_VAL, "rd_data_valid");
        if (us_run_o) evt(E_RUN, "us_run");
        if (done_o) evt(E_DONE, "done");
        if (busy_o && !busy_p) evt(E_BR, "busy_rise");
        if (!busy_o && busy_p) evt(E_BF, "busy_fall");
        if (err_o && !err_p) evt(E_ER, "err_rise");
        if (!err_o && err_p) evt(E_EF, "err_fall");
        busy_p <= busy_o;
        err_p  <= err_o;
    end

    task automatic drive(input logic s, input logic st, input logic ds, input logic us, input logic m);
        start_i = s; stall_i = st; ds_done_i = ds; us_done_i = us; mode_i = m;
        @(posedge clk); #1;
    endtask

    function automatic logic rnd(input int k);
        return ($urandom_range(k - 1) == 0);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_en"}, int'(rom_en_o), 0);
        check({tag, "_rom_addr"}, int'(rom_addr_o), 0);
        check({tag, "_rd_valid"}, int'(rd_data_valid_o), 0);
        check({tag, "_us_run"}, int'(us_run_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_err"}, int'(err_o), 0);
    endtask

    // Frame timeline in cycles relative to the accept cycle (r = 0):
    // reads issue on non-stalled cycles from r = 1, WAIT_DS starts the cycle after the
    // last valid, and each handshake resolves per the done/timeout rules.
    task automatic run_frame(input bit mode, input int stall_pct, input bit ds_none, input int ds_rel,
                             input bit us_none, input int us_rel, input int rst_addr, input int gap);
        bit st[MAXR];
        int iss[NPIX];
        int t0, n, r, lv, w, d, x, u, endr, rc, lim, last;
        bit to;
        t0 = cyc;
        for (int i = 0; i < MAXR; i++)
            st[i] = (stall_pct < 0) ? (i >= 3 && i <= 6)
                                    : (i < 100 && int'($urandom_range(99)) < stall_pct);
        n = 0;
        r = 1;
        while (n < NPIX) begin
            if (!st[r]) begin
                iss[n] = r;
                n++;
            end
            r++;
        end
        lv = iss[NPIX-1] + LAT;
        w  = lv + 1;
        d  = ds_none ? -1 : ((lv + ds_rel < 1) ? 1 : lv + ds_rel);
        if (d > w + TMO - 1) d = -1;
        x = -1; u = -1; to = 1'b0; endr = 0;
        if (d < 0) begin
            to = 1'b1;
            endr = w + TMO - 1;
        end else begin
            x = ((d > w) ? d : w) + 1;
            if (!mode) endr = x;
            else begin
                u = us_none ? -1 : x + us_rel;
                if (u > x + TMO) u = -1;
                if (u < 0) begin
                    to = 1'b1;
                    endr = x + TMO;
                end else endr = ((u > x + 1) ? u : x + 1) + 1;
            end
        end
        rc = (rst_addr >= 0) ? iss[rst_addr] : -1;

        for (int a = 0; a < NPIX; a++) begin
            if (rc < 0 || iss[a] < rc) begin
                eq[E_EN].push_back(t0 + iss[a]);
                q_addr.push_back(a);
            end
            if (rc < 0 || iss[a] + LAT < rc) eq[E_VAL].push_back(t0 + iss[a] + LAT);
        end
        eq[E_BR].push_back(t0 + 1);
        if (err_exp) eq[E_EF].push_back(t0 + 1);
        err_exp = 1'b0;
        if (rc >= 0) eq[E_BF].push_back(t0 + rc);
        else begin
            eq[E_BF].push_back(t0 + endr + 1);
            if (mode && x >= 0) eq[E_RUN].push_back(t0 + x);
            if (to) begin
                eq[E_ER].push_back(t0 + endr + 1);
                err_exp = 1'b1;
            end else eq[E_DONE].push_back(t0 + endr);
        end

        lim  = (mode && x >= 0) ? x : endr + 1;
        last = (rc >= 0) ? rc - 1 : endr;
        for (int i = 0; i <= last; i++)
            drive((i == 0) ? 1'b1 : rnd(4),
                  st[i],
                  (i == d) || (mode && x >= 0 && i >= x && rnd(5)),
                  (i == u) || (i > 0 && i < lim && rnd(6)),
                  (i == 0) ? mode : rnd(2));

        if (rc >= 0) begin
            start_i = 1'b0; stall_i = 1'b0; ds_done_i = 1'b0; us_done_i = 1'b0;
            rst_n = 1'b0;
            #1;
            check_all_zero("midreset");
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        for (int g = 0; g < gap; g++) drive(1'b0, rnd(2), rnd(3), rnd(3), rnd(2));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0,  0, 1'b0,  2, 1'b0, 0, -1, 1);
        run_frame(1'b0,  0, 1'b0,  0, 1'b0, 0, -1, 0);
        run_frame(1'b1,  0, 1'b0,  1, 1'b0, 5, -1, 2);
        run_frame(1'b0, -1, 1'b0,  3, 1'b0, 0, -1, 1);
        run_frame(1'b0,  0, 1'b1,  0, 1'b0, 0, -1, 2);
        run_frame(1'b1, 20, 1'b0, -5, 1'b0, 0, -1, 0);
        run_frame(1'b0,  0, 1'b0,  2, 1'b0, 0,  7, 1);
        run_frame(1'b1,  0, 1'b0,  2, 1'b1, 0, -1, 1);
        run_frame(1'b0,  0, 1'b0,  2, 1'b0, 0, -1, 0);
        for (int f = 0; f < 40; f++) begin
            int pct;
            case ($urandom_range(3))
                0:       pct = 0;
                1:       pct = 25;
                2:       pct = 50;
                default: pct = 0;
            endcase
            run_frame(rnd(2), pct, rnd(8), int'($urandom_range(29)) - 20,
                      rnd(10), int'($urandom_range(9)),
                      rnd(10) ? int'($urandom_range(15, 2)) : -1,
                      int'($urandom_range(3)));
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        check("drain_rom_en", eq[E_EN].size(), 0);
        check("drain_rd_valid", eq[E_VAL].size(), 0);
        check("drain_us_run", eq[E_RUN].size(), 0);
        check("drain_done", eq[E_DONE].size(), 0);
        check("drain_busy_rise", eq[E_BR].size(), 0);
        check("drain_busy_fall", eq[E_BF].size(), 0);
        check("drain_err_rise", eq[E_ER].size(), 0);
        check("drain_err_fall", eq[E_EF].size(), 0);
        check("drain_addr", q_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
